// File: rtl/cam_capture_pkg.sv
// Shared types and defaults for the multi-channel camera capture block.
// FIFO entries carry the frame/line markers alongside each 16-bit pixel.
package cam_capture_pkg;

   localparam int DEF_NUM_CH     = 2;
   localparam int DEF_FIFO_DEPTH = 8;
   localparam int DEF_HCNT_W     = 11;
   localparam int PIX_W          = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_VS,
      ST_ARMED,
      ST_BYTE0,
      ST_BYTE1,
      ST_DROP
   } cap_state_t;

   typedef struct packed {
      logic             tuser;
      logic             tlast;
      logic [PIX_W-1:0] data;
   } fifo_entry_t;

endpackage

// File: rtl/cam_capture_lane.sv
// One camera channel: strobe synchronisers, byte-pairing state machine,
// one-pixel hold register, first-word fall-through FIFO and line counter.
module cam_capture_lane
   import cam_capture_pkg::*;
#(
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int HCNT_W     = DEF_HCNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        cam_din,
   input  logic              cam_pclk,
   input  logic              cam_vsync,
   input  logic              cam_href,
   input  logic              ch_en,
   input  logic              byte_swap,
   output logic [PIX_W-1:0]  m_tdata,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic              m_tuser,
   output logic              m_tlast,
   output logic              overflow,
   input  logic              ovf_clr,
   output logic [HCNT_W-1:0] line_len
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [7:0]  din_s1, din_s2;
   logic        pclk_s1, pclk_s2, pclk_s3;
   logic        vsync_s1, vsync_s2;
   logic        href_s1, href_s2, href_s3;

   cap_state_t        state;
   logic [7:0]        byte_lat;
   logic [PIX_W-1:0]  hold_data;
   logic              hold_user;
   logic              hold_valid;
   logic              sof_pend;
   logic [HCNT_W-1:0] pix_cnt;
   logic [HCNT_W-1:0] line_len_q;

   fifo_entry_t       mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [AW:0]       count;
   fifo_entry_t       head;

   logic              evt, href_fall, capture;
   logic [PIX_W-1:0]  pixel_new;
   logic              push, push_ok, push_drop, pop, full;
   fifo_entry_t       push_entry;

   // Data shares the pclk delay stage so the byte seen on an event is the one
   // the camera held stable across its pclk rising edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         din_s1   <= '0;
         din_s2   <= '0;
         pclk_s1  <= 1'b0;
         pclk_s2  <= 1'b0;
         pclk_s3  <= 1'b0;
         vsync_s1 <= 1'b0;
         vsync_s2 <= 1'b0;
         href_s1  <= 1'b0;
         href_s2  <= 1'b0;
         href_s3  <= 1'b0;
      end else begin
         din_s1   <= cam_din;
         din_s2   <= din_s1;
         pclk_s1  <= cam_pclk;
         pclk_s2  <= pclk_s1;
         pclk_s3  <= pclk_s2;
         vsync_s1 <= cam_vsync;
         vsync_s2 <= vsync_s1;
         href_s1  <= cam_href;
         href_s2  <= href_s1;
         href_s3  <= href_s2;
      end
   end

   assign evt       = pclk_s2 & ~pclk_s3;
   assign href_fall = href_s3 & ~href_s2;
   assign capture   = evt & href_s2 & ~vsync_s2;
   assign pixel_new = byte_swap ? {din_s2, byte_lat} : {byte_lat, din_s2};

   assign full      = (count == (AW+1)'(FIFO_DEPTH));
   assign pop       = m_tvalid & m_tready;
   assign push_ok   = push & (~full | pop);
   assign push_drop = push & full & ~pop;

   // A fresh pixel evicts the held one; the end of href flushes it as the line's last.
   always_comb begin
      push       = 1'b0;
      push_entry = '0;
      if (!vsync_s2 && hold_valid) begin
         if (state == ST_BYTE1 && capture) begin
            push       = 1'b1;
            push_entry = '{tuser: hold_user, tlast: 1'b0, data: hold_data};
         end else if ((state == ST_BYTE0 || state == ST_BYTE1) && href_fall) begin
            push       = 1'b1;
            push_entry = '{tuser: hold_user, tlast: 1'b1, data: hold_data};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= ST_IDLE;
         byte_lat   <= '0;
         hold_data  <= '0;
         hold_user  <= 1'b0;
         hold_valid <= 1'b0;
         sof_pend   <= 1'b0;
         pix_cnt    <= '0;
         line_len_q <= '0;
      end else if (state != ST_IDLE && vsync_s2) begin
         state      <= ch_en ? ST_ARMED : ST_IDLE;
         hold_valid <= 1'b0;
         sof_pend   <= 1'b1;
         pix_cnt    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (ch_en)
                  state <= ST_WAIT_VS;
            end
            ST_ARMED: begin
               if (href_s2)
                  state <= ST_BYTE0;
            end
            ST_BYTE0, ST_BYTE1: begin
               if (capture && state == ST_BYTE0) begin
                  byte_lat <= din_s2;
                  state    <= ST_BYTE1;
               end else if (capture) begin
                  if (push_drop) begin
                     state      <= ST_DROP;
                     hold_valid <= 1'b0;
                  end else begin
                     hold_data  <= pixel_new;
                     hold_user  <= sof_pend;
                     hold_valid <= 1'b1;
                     sof_pend   <= 1'b0;
                     pix_cnt    <= (&pix_cnt) ? pix_cnt : pix_cnt + HCNT_W'(1);
                     state      <= ST_BYTE0;
                  end
               end else if (href_fall) begin
                  // An odd trailing byte in byte_lat is simply abandoned here.
                  state      <= push_drop ? ST_DROP : ST_BYTE0;
                  hold_valid <= 1'b0;
                  pix_cnt    <= '0;
                  if (!push_drop)
                     line_len_q <= pix_cnt;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= push_entry;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Clear has priority so a pulse coinciding with a drop still leaves the flag low.
   always_ff @(posedge clk) begin
      if (!reset)
         overflow <= 1'b0;
      else if (ovf_clr)
         overflow <= 1'b0;
      else if (push_drop)
         overflow <= 1'b1;
   end

   assign head     = mem[rd_ptr];
   assign m_tvalid = (count != '0);
   assign m_tdata  = m_tvalid ? head.data  : '0;
   assign m_tuser  = m_tvalid ? head.tuser : 1'b0;
   assign m_tlast  = m_tvalid ? head.tlast : 1'b0;
   assign line_len = line_len_q;

endmodule

// File: rtl/cam_capture_mc.sv
// Multi-channel camera capture: NUM_CH fully independent capture lanes that
// share only the clock, reset, byte order select and overflow clear.
module cam_capture_mc
   import cam_capture_pkg::*;
#(
   parameter int NUM_CH     = DEF_NUM_CH,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int HCNT_W     = DEF_HCNT_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_CH*8-1:0]      cam_din,
   input  logic [NUM_CH-1:0]        cam_pclk,
   input  logic [NUM_CH-1:0]        cam_vsync,
   input  logic [NUM_CH-1:0]        cam_href,
   input  logic [NUM_CH-1:0]        ch_en,
   input  logic                     byte_swap,
   output logic [NUM_CH*16-1:0]     m_tdata,
   output logic [NUM_CH-1:0]        m_tvalid,
   input  logic [NUM_CH-1:0]        m_tready,
   output logic [NUM_CH-1:0]        m_tuser,
   output logic [NUM_CH-1:0]        m_tlast,
   output logic [NUM_CH-1:0]        overflow,
   input  logic                     ovf_clr,
   output logic [NUM_CH*HCNT_W-1:0] line_len
);

   for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
      cam_capture_lane #(
         .FIFO_DEPTH (FIFO_DEPTH),
         .HCNT_W     (HCNT_W)
      ) u_lane (
         .clk       (clk),
         .reset     (reset),
         .cam_din   (cam_din[8*c +: 8]),
         .cam_pclk  (cam_pclk[c]),
         .cam_vsync (cam_vsync[c]),
         .cam_href  (cam_href[c]),
         .ch_en     (ch_en[c]),
         .byte_swap (byte_swap),
         .m_tdata   (m_tdata[16*c +: 16]),
         .m_tvalid  (m_tvalid[c]),
         .m_tready  (m_tready[c]),
         .m_tuser   (m_tuser[c]),
         .m_tlast   (m_tlast[c]),
         .overflow  (overflow[c]),
         .ovf_clr   (ovf_clr),
         .line_len  (line_len[HCNT_W*c +: HCNT_W])
      );
   end

endmodule
